// File: rtl/sdram_port_arbiter_if.sv
// Requester-side (download writer, tape and FDD read ports) and SDRAM controller signals of the port arbiter.
// slave is the arbiter's view; master is the view of whatever drives the requesters and the controller.
interface sdram_port_arbiter_if #(
    parameter int AW = 25,
    parameter int DW = 16
);
    logic          dl_active;
    logic          dl_wr;
    logic [AW-1:0] dl_addr;
    logic [DW-1:0] dl_data;
    logic          tape_rd;
    logic [AW-1:0] tape_addr;
    logic [DW-1:0] tape_data;
    logic          tape_stb;
    logic          fdd_rd;
    logic [AW-1:0] fdd_addr;
    logic [DW-1:0] fdd_data;
    logic          fdd_stb;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic          mem_we;
    logic          mem_rd;
    logic [DW-1:0] mem_dout;
    logic          mem_ready;
    logic          ovf;
    logic          tmo;

    modport slave (
        input  dl_active, dl_wr, dl_addr, dl_data,
        input  tape_rd, tape_addr, fdd_rd, fdd_addr,
        input  mem_dout, mem_ready,
        output tape_data, tape_stb, fdd_data, fdd_stb,
        output mem_addr, mem_din, mem_we, mem_rd, ovf, tmo
    );

    modport master (
        output dl_active, dl_wr, dl_addr, dl_data,
        output tape_rd, tape_addr, fdd_rd, fdd_addr,
        output mem_dout, mem_ready,
        input  tape_data, tape_stb, fdd_data, fdd_stb,
        input  mem_addr, mem_din, mem_we, mem_rd, ovf, tmo
    );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM port between the ioctl download writer (2-deep write FIFO) and the tape/FDD read ports.
// Read pulse N -> mem_rd N+2, mem_ready M -> stb M+1; no backpressure: full-FIFO writes drop (ovf), repeat reads merge.
module sdram_port_arbiter #(
    parameter int AW      = 25,
    parameter int DW      = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic                CLKSYS,
    input  logic                reset,
    sdram_port_arbiter_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, WAIT} state_t;
    typedef enum logic [1:0] {OP_WR, OP_TAPE, OP_FDD} op_t;
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_ent_t;

    state_t        state, state_nxt;
    op_t           op, op_nxt;
    logic          grant, done, timed_out;
    logic [CW-1:0] tmo_cnt;
    logic          tape_pend, fdd_pend;
    logic          last_fdd;

    wr_ent_t       fifo_q [2];
    logic          fifo_wp, fifo_rp;
    logic [1:0]    fifo_cnt;
    logic          push, pop;
    logic          done_tape, done_fdd;

    assign push      = bus.dl_wr && (fifo_cnt != 2'd2);
    assign pop       = done && (op == OP_WR);
    assign done_tape = done && (op == OP_TAPE);
    assign done_fdd  = done && (op == OP_FDD);

    always_ff @(posedge CLKSYS or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            op    <= OP_WR;
        end else begin
            state <= state_nxt;
            op    <= op_nxt;
        end
    end

    // Queued writes always win the IDLE decision; reads wait out an active download.
    always_comb begin
        state_nxt = state;
        op_nxt    = op;
        grant     = 1'b0;
        done      = 1'b0;
        timed_out = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_cnt != 2'd0) begin
                    grant  = 1'b1;
                    op_nxt = OP_WR;
                end else if (!bus.dl_active && (tape_pend || fdd_pend)) begin
                    grant = 1'b1;
                    if (tape_pend && fdd_pend)
                        op_nxt = last_fdd ? OP_TAPE : OP_FDD;
                    else
                        op_nxt = tape_pend ? OP_TAPE : OP_FDD;
                end
                if (grant)
                    state_nxt = WAIT;
            end
            WAIT: begin
                if (bus.mem_ready) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end else if (tmo_cnt == '0) begin
                    done      = 1'b1;
                    timed_out = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLKSYS or posedge reset) begin
        if (reset) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            fifo_wp   <= 1'b0;
            fifo_rp   <= 1'b0;
            fifo_cnt  <= 2'd0;
        end else begin
            if (push) begin
                fifo_q[fifo_wp] <= {bus.dl_addr, bus.dl_data};
                fifo_wp         <= ~fifo_wp;
            end
            if (pop)
                fifo_rp <= ~fifo_rp;
            fifo_cnt <= fifo_cnt + 2'(push) - 2'(pop);
        end
    end

    always_ff @(posedge CLKSYS or posedge reset) begin
        if (reset) begin
            bus.mem_addr  <= '0;
            bus.mem_din   <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_rd    <= 1'b0;
            bus.tape_data <= '0;
            bus.tape_stb  <= 1'b0;
            bus.fdd_data  <= '0;
            bus.fdd_stb   <= 1'b0;
            bus.ovf       <= 1'b0;
            bus.tmo       <= 1'b0;
            tmo_cnt       <= '0;
            tape_pend     <= 1'b0;
            fdd_pend      <= 1'b0;
            last_fdd      <= 1'b1;
        end else begin
            bus.mem_we   <= grant && (op_nxt == OP_WR);
            bus.mem_rd   <= grant && (op_nxt != OP_WR);
            bus.tape_stb <= done_tape;
            bus.fdd_stb  <= done_fdd;
            bus.ovf      <= bus.ovf || (bus.dl_wr && !push);
            bus.tmo      <= bus.tmo || timed_out;

            if (grant) begin
                tmo_cnt <= CW'(TIMEOUT);
                case (op_nxt)
                    OP_WR: begin
                        bus.mem_addr <= fifo_q[fifo_rp].addr;
                        bus.mem_din  <= fifo_q[fifo_rp].data;
                    end
                    OP_TAPE: bus.mem_addr <= bus.tape_addr;
                    default: bus.mem_addr <= bus.fdd_addr;
                endcase
                if (op_nxt != OP_WR)
                    last_fdd <= (op_nxt == OP_FDD);
            end else if (state == WAIT && tmo_cnt != '0) begin
                tmo_cnt <= tmo_cnt - CW'(1);
            end

            // An expired read still completes, returning zero.
            if (done_tape)
                bus.tape_data <= timed_out ? '0 : bus.mem_dout;
            if (done_fdd)
                bus.fdd_data <= timed_out ? '0 : bus.mem_dout;

            tape_pend <= (tape_pend && !done_tape) || (bus.tape_rd && !tape_pend);
            fdd_pend  <= (fdd_pend && !done_fdd) || (bus.fdd_rd && !fdd_pend);
        end
    end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench: directed scenarios then randomized traffic against a transaction-level SDRAM/requester model.
module tb_sdram_port_arbiter;
    localparam int AW      = 25;
    localparam int DW      = 16;
    localparam int TIMEOUT = 8;

    logic CLKSYS = 1'b0;
    logic reset  = 1'b1;
    always #5 CLKSYS = ~CLKSYS;

    sdram_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();
    sdram_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .CLKSYS (CLKSYS),
        .reset  (reset),
        .bus    (bus)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            cyc;
    } wexp_t;

    int cyc = 0;
    int checks = 0, failures = 0;
    int we_cnt = 0, rd_cnt = 0, tape_done = 0, fdd_done = 0;
    int last_rd_cyc = 0, tape_stb_cyc = 0, fdd_stb_cyc = 0;
    int tape_issued = 0, fdd_issued = 0, w_push = 0;
    int fixed_delay = 0;
    bit use_fixed = 0;
    logic [DW-1:0] fixed_dout = '0;
    int resp_cyc = -1;
    logic [DW-1:0] resp_val = '0;
    bit tmo_exp = 0;
    logic dla_prev = 1'b0;

    wexp_t         wr_exp[$];
    logic [DW-1:0] tape_exp[$];
    logic [DW-1:0] fdd_exp[$];
    int            grant_log[$];
    logic [DW-1:0] dl_tbl [3];

    int            m_d;
    logic [DW-1:0] m_v;
    wexp_t         m_e;
    bit            m_old;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
        return (a[15:0] * 16'h9E37) ^ 16'h1234;
    endfunction

    always @(posedge CLKSYS) cyc <= cyc + 1;

    // SDRAM model: answers each command after the chosen delay, otherwise drives noise.
    initial begin
        bus.mem_ready = 1'b0;
        bus.mem_dout  = '0;
        forever begin
            @(posedge CLKSYS);
            #1;
            if (!reset && cyc == resp_cyc) begin
                bus.mem_ready = 1'b1;
                bus.mem_dout  = resp_val;
            end else begin
                bus.mem_ready = 1'b0;
                bus.mem_dout  = DW'($urandom);
            end
        end
    end

    // Monitor: schedules responses, records expectations, pops and compares.
    always @(negedge CLKSYS) begin
        if (reset) begin
            wr_exp.delete();
            tape_exp.delete();
            fdd_exp.delete();
            resp_cyc = -1;
            tmo_exp  = 0;
            dla_prev = 1'b0;
        end else begin
            if (bus.mem_we || bus.mem_rd) begin
                m_d = (fixed_delay != 0) ? fixed_delay :
                      (($urandom % 5) == 0) ? -1 : 1 + int'($urandom % 5);
                m_v = use_fixed ? fixed_dout : mem_val(bus.mem_addr);
                resp_cyc = (m_d < 0) ? -1 : cyc + m_d;
                resp_val = m_v;
                if (m_d < 0) tmo_exp = 1;
            end
            if (bus.mem_we) begin
                we_cnt++;
                grant_log.push_back(3);
                chk("wr_expected", 32'(wr_exp.size() > 0), 32'd1);
                if (wr_exp.size() > 0) begin
                    m_e = wr_exp.pop_front();
                    chk("wr_addr", 32'(bus.mem_addr), 32'(m_e.addr));
                    chk("wr_data", 32'(bus.mem_din), 32'(m_e.data));
                end
            end
            if (bus.mem_rd) begin
                rd_cnt++;
                last_rd_cyc = cyc;
                chk("rd_while_dl_active", 32'(dla_prev), 32'd0);
                m_old = (wr_exp.size() > 0) && (wr_exp[0].cyc <= cyc - 2);
                chk("rd_before_queued_wr", 32'(m_old), 32'd0);
                if (bus.mem_addr[9:8] == 2'b01) begin
                    chk("tape_rd_addr", 32'(bus.mem_addr), 32'(bus.tape_addr));
                    tape_exp.push_back((m_d < 0) ? '0 : m_v);
                    grant_log.push_back(1);
                end else begin
                    chk("fdd_rd_addr", 32'(bus.mem_addr), 32'(bus.fdd_addr));
                    fdd_exp.push_back((m_d < 0) ? '0 : m_v);
                    grant_log.push_back(2);
                end
            end
            if (bus.tape_stb) begin
                tape_done++;
                tape_stb_cyc = cyc;
                chk("tape_stb_expected", 32'(tape_exp.size() > 0), 32'd1);
                if (tape_exp.size() > 0)
                    chk("tape_data", 32'(bus.tape_data), 32'(tape_exp.pop_front()));
            end
            if (bus.fdd_stb) begin
                fdd_done++;
                fdd_stb_cyc = cyc;
                chk("fdd_stb_expected", 32'(fdd_exp.size() > 0), 32'd1);
                if (fdd_exp.size() > 0)
                    chk("fdd_data", 32'(bus.fdd_data), 32'(fdd_exp.pop_front()));
            end
            dla_prev = bus.dl_active;
        end
    end

    task automatic drive_wr(input logic [AW-1:0] a, input logic [DW-1:0] dd, input bit kept);
        wexp_t e;
        bus.dl_wr   = 1'b1;
        bus.dl_addr = a;
        bus.dl_data = dd;
        if (kept) begin
            e.addr = a;
            e.data = dd;
            e.cyc  = cyc;
            wr_exp.push_back(e);
            w_push++;
        end
    endtask

    task automatic drive_tape(input logic [AW-1:0] a);
        bus.tape_addr = a;
        bus.tape_rd   = 1'b1;
        tape_issued++;
    endtask

    task automatic drive_fdd(input logic [AW-1:0] a);
        bus.fdd_addr = a;
        bus.fdd_rd   = 1'b1;
        fdd_issued++;
    endtask

    task automatic clear_pulses();
        bus.tape_rd = 1'b0;
        bus.fdd_rd  = 1'b0;
        bus.dl_wr   = 1'b0;
    endtask

    task automatic wait_reads(input string nm, input int budget);
        for (int i = 0; i < budget && (tape_done < tape_issued || fdd_done < fdd_issued); i++)
            @(posedge CLKSYS);
        #1;
        chk({nm, "_tape_done"}, tape_done, tape_issued);
        chk({nm, "_fdd_done"}, fdd_done, fdd_issued);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ord;
        int t0, f0, rd0, we0, w_ofs;
        dl_tbl = '{16'hA55A, 16'h1234, 16'hBEEF};
        bus.dl_active = 1'b0;
        bus.dl_addr   = '0;
        bus.dl_data   = '0;
        bus.tape_addr = '0;
        bus.fdd_addr  = '0;
        clear_pulses();

        // Reset state
        repeat (3) @(posedge CLKSYS);
        @(negedge CLKSYS);
        chk("rst_ctl", 32'({bus.mem_we, bus.mem_rd, bus.tape_stb, bus.fdd_stb, bus.ovf, bus.tmo}), 32'd0);
        chk("rst_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_rdata", {bus.tape_data, bus.fdd_data}, 32'd0);
        @(posedge CLKSYS); #1;
        reset = 1'b0;
        grant_log.delete();

        // Simultaneous requests twice: round-robin starting with tape
        fixed_delay = 3;
        for (int r = 0; r < 2; r++) begin
            @(posedge CLKSYS); #1;
            drive_tape(AW'(32'h110 + r));
            drive_fdd(AW'(32'h210 + r));
            @(posedge CLKSYS); #1;
            clear_pulses();
            wait_reads("tie", 60);
        end
        ord = 8'h00;
        for (int i = 0; i < 4 && i < grant_log.size(); i++)
            ord = {ord[5:0], 2'(grant_log[i])};
        chk("tie_len", grant_log.size(), 4);
        chk("tie_order", 32'(ord), 32'h66);

        // Single tape read latency
        fixed_delay = 5; use_fixed = 1; fixed_dout = 16'h00C3;
        f0 = fdd_done;
        @(posedge CLKSYS); #1;
        t0 = cyc;
        drive_tape(25'h100);
        @(posedge CLKSYS); #1;
        clear_pulses();
        wait_reads("lat", 60);
        chk("rd_latency", last_rd_cyc - t0, 2);
        chk("stb_latency", tape_stb_cyc - last_rd_cyc, 6);
        chk("tape_data_c3", 32'(bus.tape_data), 32'h00C3);
        chk("fdd_quiet", fdd_done, f0);
        use_fixed = 0;

        // Three back-to-back download words: third overflows
        fixed_delay = 4;
        we0 = we_cnt;
        @(posedge CLKSYS); #1;
        bus.dl_active = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLKSYS); #1;
            drive_wr(AW'(i), dl_tbl[i], i < 2);
        end
        @(posedge CLKSYS); #1;
        clear_pulses();
        repeat (30) @(posedge CLKSYS);
        #1;
        chk("dl_we_count", we_cnt - we0, 2);
        chk("ovf_set", 32'(bus.ovf), 32'd1);
        bus.dl_active = 1'b0;

        // Read held while downloading, write goes first
        fixed_delay = 2;
        we0 = we_cnt; rd0 = rd_cnt;
        @(posedge CLKSYS); #1;
        bus.dl_active = 1'b1;
        drive_tape(25'h120);
        @(posedge CLKSYS); #1;
        clear_pulses();
        drive_wr(25'h3, 16'h5A5A, 1'b1);
        @(posedge CLKSYS); #1;
        clear_pulses();
        repeat (10) @(posedge CLKSYS);
        #1;
        chk("hold_we", we_cnt - we0, 1);
        chk("hold_rd", rd_cnt, rd0);
        bus.dl_active = 1'b0;
        t0 = cyc;
        wait_reads("hold", 40);
        chk("release_latency", last_rd_cyc - t0, 1);

        // Controller never answers: timeout returns zero
        fixed_delay = -1;
        @(posedge CLKSYS); #1;
        drive_tape(25'h130);
        @(posedge CLKSYS); #1;
        clear_pulses();
        wait_reads("tmo", 60);
        chk("tmo_latency", tape_stb_cyc - last_rd_cyc, 9);
        chk("tmo_data", 32'(bus.tape_data), 32'd0);
        chk("tmo_set", 32'(bus.tmo), 32'd1);
        fixed_delay = 3;
        @(posedge CLKSYS); #1;
        drive_fdd(25'h230);
        @(posedge CLKSYS); #1;
        clear_pulses();
        wait_reads("after_tmo", 60);
        chk("tmo_sticky", 32'(bus.tmo), 32'd1);

        // Reset in the middle of a read
        fixed_delay = -1;
        rd0 = rd_cnt;
        @(posedge CLKSYS); #1;
        drive_tape(25'h140);
        @(posedge CLKSYS); #1;
        clear_pulses();
        for (int i = 0; i < 20 && rd_cnt == rd0; i++) @(posedge CLKSYS);
        chk("midwait_rd_seen", rd_cnt - rd0, 1);
        @(posedge CLKSYS); #1;
        reset = 1'b1;
        @(negedge CLKSYS);
        chk("midwait_rst_ctl", 32'({bus.mem_we, bus.mem_rd, bus.tape_stb, bus.fdd_stb, bus.ovf, bus.tmo}), 32'd0);
        @(posedge CLKSYS); #1;
        reset = 1'b0;
        tape_issued = tape_done;
        rd0 = rd_cnt; we0 = we_cnt;
        repeat (5) @(posedge CLKSYS);
        #1;
        chk("post_rst_no_rd", rd_cnt, rd0);
        chk("post_rst_no_we", we_cnt, we0);
        fixed_delay = 2;
        drive_tape(25'h150);
        @(posedge CLKSYS); #1;
        clear_pulses();
        wait_reads("post_rst", 40);

        // Randomized traffic
        fixed_delay = 0;
        w_ofs = w_push - we_cnt;
        for (int c = 0; c < 3000; c++) begin
            @(posedge CLKSYS); #1;
            clear_pulses();
            if ($urandom % 16 == 0) bus.dl_active = !bus.dl_active;
            if (bus.dl_active && w_push == we_cnt + w_ofs && $urandom % 3 == 0)
                drive_wr(AW'(32'h1000 + $urandom % 4096), DW'($urandom), 1'b1);
            if (tape_issued == tape_done && $urandom % 4 == 0)
                drive_tape(AW'(32'h100 + $urandom % 256));
            if (fdd_issued == fdd_done && $urandom % 4 == 0)
                drive_fdd(AW'(32'h200 + $urandom % 256));
        end
        @(posedge CLKSYS); #1;
        clear_pulses();
        bus.dl_active = 1'b0;
        wait_reads("rand", 300);
        repeat (20) @(posedge CLKSYS);
        #1;
        chk("rand_wr_drained", wr_exp.size(), 0);
        chk("rand_tmo", 32'(bus.tmo), 32'(tmo_exp));
        chk("rand_ovf", 32'(bus.ovf), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
